// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational ALU between two requesters.
// Latency: single-cycle op accepted in N -> result in N+2; EXE_MULT -> N+MULT_CYCLES+1.
// Backpressure: res_ready low parks at most one further op in DONE; both readies low until the slot frees.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   reqN_valid/ready      requester N handshake (ready is combinational)
//   reqN_val1/val2/cmd    requester N operands and command
//   alu_val1/val2/cmd     registered operands driven into the shared ALU
//   alu_out               combinational ALU result
//   res_valid/ready       result handshake
//   res_data, res_id      registered result and the requester that issued it
module alu_arbiter #(
  parameter int                     WORD_LEN    = 32,
  parameter int                     EXE_CMD_LEN = 4,
  parameter int                     MULT_CYCLES = 2,
  parameter logic [EXE_CMD_LEN-1:0] EXE_MULT    = EXE_CMD_LEN'(10)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WORD_LEN-1:0]    req0_val1,
  input  logic [WORD_LEN-1:0]    req0_val2,
  input  logic [EXE_CMD_LEN-1:0] req0_cmd,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WORD_LEN-1:0]    req1_val1,
  input  logic [WORD_LEN-1:0]    req1_val2,
  input  logic [EXE_CMD_LEN-1:0] req1_cmd,
  output logic [WORD_LEN-1:0]    alu_val1,
  output logic [WORD_LEN-1:0]    alu_val2,
  output logic [EXE_CMD_LEN-1:0] alu_cmd,
  input  logic [WORD_LEN-1:0]    alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WORD_LEN-1:0]    res_data,
  output logic                   res_id
);

  localparam int CNT_W = $clog2(MULT_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_id_q, last_id_q;
  logic [WORD_LEN-1:0]  alu_val1_q, alu_val2_q, res_data_q;
  logic [EXE_CMD_LEN-1:0] alu_cmd_q;
  logic                 res_valid_q, res_id_q;

  logic                   slot_free, can_accept, grant_id, accept, capture, mult_op;
  logic [WORD_LEN-1:0]    sel_val1, sel_val2;
  logic [EXE_CMD_LEN-1:0] sel_cmd;

  assign slot_free  = !res_valid_q || res_ready;
  assign can_accept = (state_q == S_IDLE) || ((state_q == S_DONE) && slot_free);

  // Tie goes to the requester that did not win last; a lone requester always wins.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_id_q;
    else if (req1_valid)          grant_id = 1'b1;
  end

  // Gated by rst so both readies drop the moment reset asserts, even though
  // the state register already reads IDLE during reset.
  assign req0_ready = rst && can_accept && req0_valid && !grant_id;
  assign req1_ready = rst && can_accept && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  assign sel_val1 = grant_id ? req1_val1 : req0_val1;
  assign sel_val2 = grant_id ? req1_val2 : req0_val2;
  assign sel_cmd  = grant_id ? req1_cmd  : req0_cmd;
  assign mult_op  = (sel_cmd == EXE_MULT) && (MULT_CYCLES > 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (mult_op) begin
            state_d = S_EXEC;
            cnt_d   = CNT_W'(MULT_CYCLES - 1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (slot_free) begin
          capture = 1'b1;
          // Back-to-back: the next op enters while the current result is captured.
          if (accept) begin
            if (mult_op) begin
              state_d = S_EXEC;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_id_q   <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_id_q   <= grant_id;
        last_id_q <= grant_id;
      end
    end
  end

  // ALU operands only change on accept, so they stay stable through EXEC,
  // a parked DONE and IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_val1_q <= '0;
      alu_val2_q <= '0;
      alu_cmd_q  <= '0;
    end else if (accept) begin
      alu_val1_q <= sel_val1;
      alu_val2_q <= sel_val2;
      alu_cmd_q  <= sel_cmd;
    end
  end

  // Capture wins over drain: a consumed result replaced in the same cycle keeps res_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= alu_out;
      res_id_q    <= op_id_q;
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign alu_val1  = alu_val1_q;
  assign alu_val2  = alu_val2_q;
  assign alu_cmd   = alu_cmd_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: self-checking bench for alu_arbiter (directed timing steps plus randomized traffic).
// Latency: checks exact single-cycle and multi-cycle result timing with MULT_CYCLES=3.
// Backpressure: exercises res_ready stalls, parked ops and result hold stability.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int MC = 3;

  localparam logic [CW-1:0] C_ADD  = 4'b0010;
  localparam logic [CW-1:0] C_SUB  = 4'b0100;
  localparam logic [CW-1:0] C_AND  = 4'b0110;
  localparam logic [CW-1:0] C_ORR  = 4'b0111;
  localparam logic [CW-1:0] C_EOR  = 4'b1000;
  localparam logic [CW-1:0] C_MULT = 4'b1010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [W-1:0] req0_val1 = '0, req0_val2 = '0, req1_val1 = '0, req1_val2 = '0;
  logic [CW-1:0] req0_cmd = '0, req1_cmd = '0;
  logic [W-1:0] alu_val1, alu_val2, alu_out, res_data;
  logic [CW-1:0] alu_cmd;
  logic res_valid, res_id;
  logic res_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: used both as the environment's ALU and to predict results from request payloads.
  function automatic logic [W-1:0] alu_f(input logic [CW-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_AND:   return a & b;
      C_ORR:   return a | b;
      C_EOR:   return a ^ b;
      C_MULT:  return a * b;
      default: return a;
    endcase
  endfunction

  assign alu_out = alu_f(alu_cmd, alu_val1, alu_val2);

  alu_arbiter #(.WORD_LEN(W), .EXE_CMD_LEN(CW), .MULT_CYCLES(MC), .EXE_MULT(C_MULT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_cmd(req1_cmd),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [CW-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v; req0_cmd = c; req0_val1 = a; req0_val2 = b;
  endtask

  task automatic drv1(input logic v, input logic [CW-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v; req1_cmd = c; req1_val1 = a; req1_val2 = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"},  res_data,  0);
    chk({tag, "_res_id"},    res_id,    0);
    chk({tag, "_alu_val1"},  alu_val1,  0);
    chk({tag, "_alu_val2"},  alu_val2,  0);
    chk({tag, "_alu_cmd"},   alu_cmd,   0);
    chk({tag, "_rdy0"},      req0_ready, 0);
    chk({tag, "_rdy1"},      req1_ready, 0);
  endtask

  // Transaction-level reference: expected results in acceptance order plus the last granted id.
  logic [W:0] exp_q[$];
  logic       m_last = 1'b1;
  logic       p0 = 1'b0, p1 = 1'b0;
  logic       held_vld = 1'b0;
  logic [W:0] held;
  logic [CW-1:0] cmds [6] = '{C_ADD, C_SUB, C_AND, C_ORR, C_EOR, C_MULT};

  task automatic rnd_cycle(input bit gen);
    logic       gid, exp_g;
    logic [W:0] e;
    if (gen && !p0 && $urandom_range(0, 2) != 0) begin
      drv0(1'b1, cmds[$urandom_range(0, 5)], $urandom, $urandom); p0 = 1'b1;
    end
    if (gen && !p1 && $urandom_range(0, 2) != 0) begin
      drv1(1'b1, cmds[$urandom_range(0, 5)], $urandom, $urandom); p1 = 1'b1;
    end
    req0_valid = p0;
    req1_valid = p1;
    res_ready  = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (held_vld) begin
      chk("rnd_hold_valid", res_valid, 1);
      chk("rnd_hold_data",  {res_id, res_data}, held);
    end
    chk("rnd_one_ready", req0_ready && req1_ready, 0);
    if (req0_ready || req1_ready) begin
      gid   = req1_ready;
      exp_g = (p0 && p1) ? ~m_last : p1;
      chk("rnd_grant", gid, exp_g);
      if (gid) exp_q.push_back({1'b1, alu_f(req1_cmd, req1_val1, req1_val2)});
      else     exp_q.push_back({1'b0, alu_f(req0_cmd, req0_val1, req0_val2)});
      m_last = gid;
      if (gid) p1 = 1'b0; else p0 = 1'b0;
    end
    if (res_valid && res_ready) begin
      chk("rnd_res_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rnd_res", {res_id, res_data}, e);
      end
    end
    held_vld = res_valid && !res_ready;
    held     = {res_id, res_data};
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;

    // ---- Reset state ----
    cyc(); cyc();
    drv0(1'b1, C_ADD, 5, 3);
    #1;
    chk_all_zero("rst_init");

    // ---- Release, ADD 5,3 from requester 0 ----
    rst = 1'b1;
    #1;
    chk("add_rdy0", req0_ready, 1);
    chk("add_rdy1", req1_ready, 0);
    cyc();
    drv0(1'b0, C_ADD, 0, 0);
    #1;
    chk("add_alu_val1", alu_val1, 5);
    chk("add_alu_val2", alu_val2, 3);
    chk("add_alu_cmd",  alu_cmd,  C_ADD);
    chk("add_res_valid_n1", res_valid, 0);
    cyc();
    chk("add_res_valid", res_valid, 1);
    chk("add_res_data",  res_data,  8);
    chk("add_res_id",    res_id,    0);
    cyc();
    chk("add_drained", res_valid, 0);

    // ---- Multiply latency: req1 MULT 7,6 ----
    drv1(1'b1, C_MULT, 7, 6);
    #1;
    chk("mul_rdy1", req1_ready, 1);
    cyc();
    drv1(1'b0, C_ADD, 0, 0);
    drv0(1'b1, C_ADD, 1, 1);
    #1;
    chk("mul_exec1_rdy0", req0_ready, 0);
    chk("mul_exec1_val1", alu_val1, 7);
    chk("mul_exec1_val2", alu_val2, 6);
    chk("mul_exec1_cmd",  alu_cmd,  C_MULT);
    chk("mul_exec1_res",  res_valid, 0);
    cyc();
    chk("mul_exec2_rdy0", req0_ready, 0);
    chk("mul_exec2_val1", alu_val1, 7);
    chk("mul_exec2_res",  res_valid, 0);
    cyc();
    drv0(1'b0, C_ADD, 0, 0);
    #1;
    chk("mul_done_val1", alu_val1, 7);
    chk("mul_done_res",  res_valid, 0);
    cyc();
    chk("mul_res_valid", res_valid, 1);
    chk("mul_res_data",  res_data,  42);
    chk("mul_res_id",    res_id,    1);
    cyc();
    chk("mul_drained", res_valid, 0);

    // ---- Tie fairness: SUB 10,4 vs ORR 0xF0,0x0F ----
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        drv0(1'b1, C_SUB, 10, 4);
        drv1(1'b1, C_ORR, 32'hF0, 32'h0F);
      end
      if (k == 6) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (k < 6) begin
        chk("tie_rdy0", req0_ready, (k % 2) == 0);
        chk("tie_rdy1", req1_ready, (k % 2) == 1);
      end
      if (k >= 2) begin
        chk("tie_res_valid", res_valid, 1);
        chk("tie_res_data",  res_data, ((k - 2) % 2 == 0) ? 64'd6 : 64'hFF);
        chk("tie_res_id",    res_id,   (k - 2) % 2);
      end
      cyc();
    end
    chk("tie_drained", res_valid, 0);

    // ---- Back-pressure ----
    drv0(1'b1, C_AND, 32'hC, 32'hA);
    #1;
    chk("bp_rdy_op0", req0_ready, 1);
    cyc();
    drv0(1'b1, C_ADD, 1, 2);
    #1;
    chk("bp_rdy_op1", req0_ready, 1);
    cyc();
    res_ready = 1'b0;
    drv0(1'b1, C_ADD, 3, 4);
    #1;
    chk("bp_first_valid", res_valid, 1);
    chk("bp_first_data",  res_data, 8);
    chk("bp_stall_rdy_a", req0_ready, 0);
    cyc();
    chk("bp_stall_rdy_b", req0_ready, 0);
    chk("bp_hold_data_b", res_data, 8);
    chk("bp_hold_valid_b", res_valid, 1);
    chk("bp_parked_val1", alu_val1, 1);
    cyc();
    chk("bp_stall_rdy_c", req0_ready, 0);
    chk("bp_hold_data_c", res_data, 8);
    res_ready = 1'b1;
    #1;
    chk("bp_resume_rdy", req0_ready, 1);
    cyc();
    drv0(1'b0, C_ADD, 0, 0);
    #1;
    chk("bp_q_valid", res_valid, 1);
    chk("bp_q_data",  res_data, 3);
    chk("bp_q_id",    res_id, 0);
    cyc();
    chk("bp_next_data", res_data, 7);
    cyc();
    chk("bp_drained", res_valid, 0);

    // ---- Reset mid-op ----
    drv0(1'b1, C_MULT, 2, 3);
    #1;
    chk("rmid_rdy0", req0_ready, 1);
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rmid");
    drv0(1'b0, C_ADD, 0, 0);
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rmid_no_result", res_valid, 0);
      cyc();
    end
    drv0(1'b1, C_ADD, 2, 2);
    drv1(1'b1, C_SUB, 9, 1);
    #1;
    chk("rmid_tie_rdy0", req0_ready, 1);
    chk("rmid_tie_rdy1", req1_ready, 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    chk("rmid_tie_data", res_data, 4);
    chk("rmid_tie_id",   res_id, 0);
    cyc();
    m_last = 1'b0;

    // ---- Randomized traffic against the transaction model ----
    for (int c = 0; c < 600; c++) rnd_cycle(1'b1);
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!p0 && !p1 && exp_q.size() == 0 && !res_valid) begin
        done = 1'b1;
        break;
      end
      rnd_cycle(1'b0);
    end
    chk("rnd_drain_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU in the execute stage between two requesters (pipeline EXE path and the auxiliary multi-cycle/coprocessor path) using round-robin arbitration with valid/ready handshakes. It registers the selected operands onto the ALU inputs. It holds those inputs stable for `EXE_MULT` over a configurable number of cycles, and returns the result through a registered, back-pressurable output carrying the requester ID.

## Interface
- `WORD_LEN`, 32: operand/result width, from `defines.v`.
- `EXE_CMD_LEN`, 4: command width, from `defines.v`; encodings are the `EXE_*` defines.
- `MULT_CYCLES`, 2: cycles the ALU inputs are held for `EXE_MULT`; legal values ≥ 1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_val1`, `req0_val2` in `WORD_LEN`: requester 0 operands.
- `req0_cmd` in `EXE_CMD_LEN`: requester 0 command.
- `req1_valid`, `req1_ready`, `req1_val1`, `req1_val2`, `req1_cmd`: same as the requester 0 ports, for requester 1.
- `alu_val1`, `alu_val2` out `WORD_LEN`: registered ALU operands.
- `alu_cmd` out `EXE_CMD_LEN`: registered ALU command.
- `alu_out` in `WORD_LEN`: combinational ALU result.
- `res_valid` out 1: result register holds a result.
- `res_ready` in 1: consumer takes the result.
- `res_data` out `WORD_LEN`: result.
- `res_id` out 1: requester that issued the result.

## Operation
- **Internal state**
  - `state` ∈ {IDLE, EXEC, DONE}.
  - Down-counter `cnt`, width `$clog2(MULT_CYCLES)+1`.
  - `op_id` register, 1 bit.
  - `last_id` register, 1 bit: round-robin pointer.
- **Slot availability**
  - `slot_free = !res_valid || res_ready`.
  - `done = (state==DONE)`.
  - `can_accept = (state==IDLE) || (done && slot_free)`.
- **Grant**
  - Only requester 0 valid → grant 0.
  - Only requester 1 valid → grant 1.
  - Both valid → grant `~last_id`.
  - `reqN_ready = can_accept && reqN_valid && grant==N`, combinational.
  - At most one ready is high per cycle.
  - Both readies are 0 while `rst` is low.
- **Accept** (handshake `valid && ready`)
  - Load `alu_val1`, `alu_val2`, `alu_cmd` from the granted requester; set `op_id` and `last_id` to the granted ID.
  - If cmd == `EXE_MULT` and `MULT_CYCLES>1`: `cnt <= MULT_CYCLES-1`, go to EXEC.
  - Otherwise go to DONE.
- **EXEC**
  - `cnt` decrements each cycle.
  - When `cnt==1`, next state is DONE.
  - ALU inputs are held constant.
- **DONE**
  - If `slot_free`: `res_data <= alu_out`, `res_id <= op_id`, `res_valid <= 1`.
    - If an accept occurs in the same cycle, take the EXEC/DONE entry for the new op (back-to-back).
    - Otherwise go to IDLE.
  - If not `slot_free`: stay in DONE with ALU inputs held.
- **Result drain**: `res_valid && res_ready` with no capture in the same cycle → `res_valid <= 0`. Capture takes priority.
- **Requester rules**
  - A requester holds valid and payload stable until ready.
  - Valid may rise in any cycle.
  - The arbiter never drops an accepted operation.
- **Idle ALU inputs**: in IDLE, `alu_*` keep their last values; they are not zeroed.
- **Reset (asynchronous)**
  - State → IDLE, `cnt` → 0, `last_id` → 1 (requester 0 wins the first tie).
  - `op_id`, `res_id`, `res_data`, `alu_val1`, `alu_val2`, `alu_cmd` → 0; `res_valid` → 0.
  - An in-flight operation is discarded with no result.

## Timing
- **Single-cycle op**: accepted in cycle N → ALU inputs valid in N+1 (DONE) → `res_valid`/`res_data` in N+2 when the slot is free.
- **`EXE_MULT`**: accepted in N → EXEC for cycles N+1..N+MULT_CYCLES-1 → DONE in N+MULT_CYCLES → result in N+MULT_CYCLES+1.
- **Throughput**
  - Single-cycle ops sustain one per cycle with `res_ready=1`.
  - `EXE_MULT` ops issue one per `MULT_CYCLES` cycles.
- **Back-pressure**
  - `res_ready=0` with `res_valid=1` holds `res_data`/`res_id` stable.
  - The arbiter absorbs at most one further op, parked in DONE.
  - Both readies stay low until the slot frees.
- **Reset timing**: outputs change immediately on `rst` falling, independent of `clk`; normal operation resumes at the first edge after `rst` rises.

## Test plan
- **Reset**: assert `rst`=0 mid-cycle → all outputs 0 and readies 0 immediately. Release, then `req0` ADD 5,3 → `req0_ready` in cycle 0, `res_data`=8, `res_id`=0 in cycle 2.
- **Tie fairness**: both valid continuously, `req0` SUB 10,4 and `req1` OR 0xF0,0x0F → grants 0,1,0,1. Results alternate 6 (id0), 0xFF (id1), one per cycle.
- **Multiply latency** (`MULT_CYCLES`=3): `req1` MULT 7,6 → `res_data`=42, `res_id`=1 three cycles after the ALU inputs load (4 after accept). Readies stay low during EXEC; `alu_*` stay constant.
- **Back-pressure**: `res_ready`=0 after the first result (AND 0xC,0xA → 8) while `req0` streams → one more op is accepted, then readies stay low and `res_data` holds 8. Raising `res_ready` → the queued result appears the next cycle and streaming resumes.
- **Reset mid-op**: MULT in EXEC, then `rst` low one cycle → no result is produced and the state returns to IDLE. After release, a tie grants requester 0 first.
